// File: rtl/x74_div4_pkg.sv
// Shared definitions for the x74_div4 restoring divider: FSM state encoding and default width.
package x74_div4_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/x74_sub4.sv
// Trial subtractor stage: a + ~b + 1, with borrow reported as the inverted carry-out.
module x74_sub4 #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int unsigned SW = W + 1;

  logic [W:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + SW'(1);
  assign diff   = sum[W-1:0];
  assign borrow = ~sum[W];

endmodule

// File: rtl/x74_div4.sv
// Multi-cycle restoring unsigned divider with start/busy/done handshake;
// one quotient bit per cycle, divide-by-zero short-circuits to a flagged result.
module x74_div4
  import x74_div4_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div0
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [RW-1:0]    r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [RW-1:0]    r_sh;
  logic [RW-1:0]    diff;
  logic             borrow;
  logic [RW-1:0]    r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept;

  // One iteration: shift {R,Q} left, trial-subtract D, restore on borrow.
  assign r_sh = (r << 1) | RW'(q[WIDTH-1]);
  assign r_nx = borrow ? r_sh : diff;
  assign q_nx = {q[WIDTH-2:0], ~borrow};

  x74_sub4 #(.W(RW)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, d}),
    .diff   (diff),
    .borrow (borrow)
  );

  // FIN without DONE is the pending divide-by-zero cycle; it must not be overrun.
  assign accept = start && ((state == ST_IDLE) || ((state == ST_FIN) && done));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (accept) begin
            q    <= dividend;
            d    <= divisor;
            r    <= '0;
            div0 <= 1'b0;
            cnt  <= CW'(WIDTH);
            if (divisor != '0) begin
              busy  <= 1'b1;
              state <= ST_RUN;
            end else begin
              state <= ST_FIN;
            end
          end else if ((state == ST_FIN) && !done) begin
            done  <= 1'b1;
            div0  <= 1'b1;
            quo   <= '1;
            rem   <= q;
            state <= ST_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo   <= q_nx;
            rem   <= r_nx[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x74_div4.sv
// Scoreboard bench for x74_div4: directed cases, exhaustive sweep and randomized traffic
// checked against a plain / and % reference.
module tb_x74_div4;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         div0;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div0;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  x74_div4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned / and %, all-ones quotient and dividend remainder on zero divisor.
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.div0 = (b == 0);
    e.quo  = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    e.rem  = (b == 0) ? a : W'(int'(a) % int'(b));
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_20 at %0t", $time);
    end else begin
      @(negedge clk);
    end
  endtask

  // Monitor: every DONE pops one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quo", int'(quo), int'(e.quo));
        chk("rem", int'(rem), int'(e.rem));
        chk("div0", int'(div0), int'(e.div0));
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quo", int'(quo), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_div0", int'(div0), 0);
    rst = 1'b0;

    // 13/4 with cycle-exact busy/done timing
    go(4'd13, 4'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_busy", int'(busy), 1);
      chk("t1_done_early", int'(done), 0);
      @(negedge clk);
    end
    chk("t1_done", int'(done), 1);
    @(negedge clk);

    go(4'd15, 4'd1); wait_done();
    go(4'd7, 4'd9);  wait_done();
    go(4'd0, 4'd5);  wait_done();

    // Divide by zero: DONE one cycle after accept, BUSY never high
    go(4'd9, 4'd0);
    chk("dz_busy0", int'(busy), 0);
    chk("dz_done0", int'(done), 0);
    @(negedge clk);
    chk("dz_busy1", int'(busy), 0);
    chk("dz_done1", int'(done), 1);
    @(negedge clk);

    // START while busy is ignored
    go(4'd12, 4'd5);
    @(negedge clk);
    dividend = 4'd3;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-operation discards the result
    go(4'd14, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_quo", int'(quo), 0);
    chk("mid_rst_rem", int'(rem), 0);
    chk("mid_rst_div0", int'(div0), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    go(4'd6, 4'd2); wait_done();

    // Back-to-back: START held through the DONE cycle
    go(4'd13, 4'd4);
    repeat (3) @(negedge clk);
    begin
      exp_t e;
      dividend = 4'd10;
      divisor  = 4'd3;
      start    = 1'b1;
      e.quo = 4'd3; e.rem = 4'd1; e.div0 = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("b2b_first_done", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("b2b_done_early", int'(done), 0);
    @(negedge clk);
    chk("b2b_done", int'(done), 1);
    @(negedge clk);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        go(W'(a), W'(b));
        wait_done();
      end
    end

    // Randomized traffic with stray START pulses while busy
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int gap;
      a = W'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      go(a, b);
      if (b != 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        dividend = W'($urandom);
        divisor  = W'($urandom);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
